wide_serial_subtractor: RTL and testbench
=========================================

Name: wide_serial_subtractor

Overview:
Area-optimised W-bit unsigned subtractor computing diff = a - b - b_in, plus the borrow-out. It is the subtract-direction counterpart of the wide parallel adder. It processes one M-bit chunk per cycle, LSB chunk first, with a registered borrow between chunks. It sits in the same big-integer datapath and uses valid/ready handshakes on both sides, so it can be placed between skid buffers or FIFOs.

Parameters:
W, 2048, total operand width in bits; must be a multiple of M.
M, 64, chunk width processed per cycle.
N, W/M, number of chunks (derived localparam, not overridable).

Ports:
clk  in  1  clock.
rst  in  1  reset, synchronous, active-high.
a  in  W  minuend; sampled on the input handshake.
b  in  W  subtrahend; sampled on the input handshake.
b_in  in  1  borrow-in; sampled on the input handshake.
in_valid  in  1  input operands are valid.
in_ready  out  1  block can accept an operation this cycle.
diff  out  W  result, a - b - b_in modulo 2^W.
b_out  out  1  borrow-out; 1 iff a < b + b_in (unsigned).
out_valid  out  1  diff and b_out are valid.
out_ready  in  1  downstream accepts the result.
busy  out  1  high while in state RUN.

Behaviour:
- Reset: state=IDLE; in_ready=1, out_valid=0, busy=0, diff=0, b_out=0; chunk counter=0; borrow register=0.
- States: IDLE, RUN, DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- Input accept occurs when in_valid && in_ready. On accept:
  - latch a and b into shift registers;
  - borrow register <= b_in;
  - counter <= 0;
  - state <= RUN.
- RUN, each cycle:
  - {bw, d} = a_sr[M-1:0] - b_sr[M-1:0] - borrow, computed as an (M+1)-bit subtract.
  - d is shifted into diff from the top; diff shifts right by M.
  - a_sr and b_sr shift right by M.
  - borrow <= bw; counter++.
  - When counter==N-1: b_out <= bw, state <= DONE, out_valid <= 1.
- Latency: out_valid rises exactly N clock edges after the accept edge (32 for the defaults). Throughput is one operation per N+1 cycles when out_ready is held high.
- DONE:
  - out_valid=1; diff and b_out are held stable while out_ready=0.
  - If out_ready=1: the result is consumed. If in_valid=1 in the same cycle, the new operation is accepted and the next state is RUN; otherwise the next state is IDLE.
  - out_valid drops on the edge after consumption unless a new result completes, which cannot happen on that edge.
- in_valid during RUN is ignored (in_ready=0) and no operand is sampled. The upstream must hold its data.
- out_ready outside DONE has no effect.
- diff is only meaningful while out_valid=1. Partial shift contents are visible during RUN and carry no meaning.
- rst asserted mid-RUN or in DONE: the operation is discarded and every register returns to its reset value on that edge. No out_valid pulse is produced for the aborted operation.
- N==1: RUN lasts exactly one cycle; the same rules apply.
- All arithmetic is unsigned, with no saturation. Wrap-around is modulo 2^W and is reported via b_out.

Decomposition:
- Package wide_sub_pkg: default W/M constants, the state enum type (IDLE/RUN/DONE), and a function computing N with a static check that W % M == 0.
- One natural sub-module: chunk_sub, a combinational M-bit subtract. Inputs x, y, bi; outputs d, bo. Instantiated once and reused every cycle.

Test Plan:
1. a=5, b=3, b_in=0, out_ready=1 -> out_valid exactly 32 cycles after accept; diff=2, b_out=0; in_ready=1 in the DONE cycle.
2. a=0, b=1, b_in=0 -> diff=2^2048-1 (all ones), b_out=1; the borrow propagates through all 32 chunks.
3. a=2^64, b=1, b_in=0 -> diff=2^64-1 (chunk0 all ones, chunk1=0), b_out=0. Also a=b=2^2048-1, b_in=1 -> diff=all ones, b_out=1.
4. Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, diff/b_out stable, in_ready=0. Then out_ready=1 with in_valid=1 and new operands 9-4 -> same-edge handoff; the next result is diff=5, 32 edges later.
5. rst pulsed at counter=10 during RUN -> next cycle out_valid=0, in_ready=1, busy=0, diff=0. A following 7-7 operation gives diff=0, b_out=0.
6. Random regression: 1000 random a, b, b_in with random in_valid/out_ready gaps, checked against a reference model of a-b-b_in -> all results match; every accept yields exactly one out_valid transaction, in order.

Source files
------------

// File: rtl/wide_sub_pkg.sv
// Shared definitions for the wide serial subtractor: default sizes,
// controller state encoding and chunk-count derivation.
package wide_sub_pkg;

    localparam int unsigned DEF_W = 32'd2048;
    localparam int unsigned DEF_M = 32'd64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of M-bit chunks in a W-bit operand; 0 flags an illegal pairing
    // (W not a positive multiple of M) so the user can reject it at elaboration.
    function automatic int unsigned num_chunks(input int unsigned w, input int unsigned m);
        if ((m == 32'd0) || (w == 32'd0) || ((w % m) != 32'd0)) begin
            return 32'd0;
        end else begin
            return w / m;
        end
    endfunction

endpackage

// File: rtl/chunk_sub.sv
// Combinational M-bit subtract with borrow-in and borrow-out.
// The borrow-out is the top bit of an (M+1)-bit subtraction.
module chunk_sub
    import wide_sub_pkg::*;
#(
    parameter int unsigned M = DEF_M
) (
    input  logic [M-1:0] x,
    input  logic [M-1:0] y,
    input  logic         bi,
    output logic [M-1:0] d,
    output logic         bo
);

    logic [M:0] full_s;

    // Widen both operands by one zero bit so a negative result shows as bit M.
    always_comb begin
        full_s = {1'b0, x} - {1'b0, y} - {{M{1'b0}}, bi};
    end

    assign d  = full_s[M-1:0];
    assign bo = full_s[M];

endmodule

// File: rtl/wide_serial_subtractor.sv
// W-bit unsigned subtractor diff = a - b - b_in, processed one M-bit chunk
// per cycle (LSB chunk first) through a single reused chunk_sub, with a
// registered borrow between chunks and valid/ready handshakes on both sides.
module wide_serial_subtractor
    import wide_sub_pkg::*;
#(
    parameter int unsigned W = DEF_W,
    parameter int unsigned M = DEF_M
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         b_in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] diff,
    output logic         b_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);

    localparam int unsigned N  = num_chunks(W, M);
    localparam int unsigned CW = (N > 32'd1) ? $clog2(N) : 32'd1;
    localparam logic [CW-1:0] LAST_CHUNK = CW'(N - 32'd1);

    // Reject a width pairing that does not split into whole chunks.
    if (N == 32'd0) begin : g_width_check
        $error("wide_serial_subtractor: W must be a positive multiple of M");
    end

    state_t         state_r;
    state_t         state_next_s;
    logic [W-1:0]   a_sr_r;
    logic [W-1:0]   b_sr_r;
    logic [W-1:0]   diff_r;
    logic [W-1:0]   diff_shift_s;
    logic           b_out_r;
    logic           borrow_r;
    logic [CW-1:0]  cnt_r;
    logic [M-1:0]   chunk_d_s;
    logic           chunk_bo_s;
    logic           accept_s;
    logic           last_s;
    logic           in_ready_s;

    chunk_sub #(
        .M (M)
    ) u_chunk_sub (
        .x  (a_sr_r[M-1:0]),
        .y  (b_sr_r[M-1:0]),
        .bi (borrow_r),
        .d  (chunk_d_s),
        .bo (chunk_bo_s)
    );

    // New chunk enters the result from the top; with a single chunk it is the whole result.
    if (N == 32'd1) begin : g_diff_single
        assign diff_shift_s = chunk_d_s;
    end else begin : g_diff_multi
        assign diff_shift_s = {chunk_d_s, diff_r[W-1:M]};
    end

    // Handshake decode: a finished result being consumed frees the slot in the same cycle.
    always_comb begin
        in_ready_s = 1'b0;
        accept_s   = 1'b0;
        last_s     = 1'b0;
        if ((state_r == IDLE) || ((state_r == DONE) && out_ready)) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end
        accept_s = in_valid && in_ready_s;
        if ((state_r == RUN) && (cnt_r == LAST_CHUNK)) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end
    end

    // Next-state logic for the IDLE/RUN/DONE controller.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE: begin
                if (out_ready && in_valid) begin
                    state_next_s = RUN;
                end else if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand shift registers, chunk counter, inter-chunk borrow and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr_r   <= '0;
            b_sr_r   <= '0;
            diff_r   <= '0;
            b_out_r  <= 1'b0;
            borrow_r <= 1'b0;
            cnt_r    <= '0;
        end else if (accept_s) begin
            a_sr_r   <= a;
            b_sr_r   <= b;
            borrow_r <= b_in;
            cnt_r    <= '0;
        end else if (state_r == RUN) begin
            a_sr_r   <= a_sr_r >> M;
            b_sr_r   <= b_sr_r >> M;
            diff_r   <= diff_shift_s;
            borrow_r <= chunk_bo_s;
            cnt_r    <= cnt_r + CW'(1);
            if (last_s) begin
                b_out_r <= chunk_bo_s;
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = (state_r == DONE);
    assign busy      = (state_r == RUN);
    assign diff      = diff_r;
    assign b_out     = b_out_r;

endmodule

// File: tb/tb_wide_serial_subtractor.sv
// Scoreboard bench for wide_serial_subtractor: the driver pushes the
// arithmetic expectation of each accepted operation; an independent monitor
// pops and compares whenever a result is handed downstream.
module tb_wide_serial_subtractor;

    localparam int W = 2048;
    localparam int M = 64;
    localparam int N = W / M;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        int           acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         b_in;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] diff;
    logic         b_out;
    logic         out_valid;
    logic         out_ready;
    logic         busy;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_acc = 0;
    int   n_res = 0;
    bit   seen = 0;
    bit   rand_or = 0;

    wide_serial_subtractor #(.W(W), .M(M)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .b_in(b_in),
        .in_valid(in_valid), .in_ready(in_ready),
        .diff(diff), .b_out(b_out), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_wide(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual hi=%h lo=%h required hi=%h lo=%h",
                     name, cyc, act[W-1:W-64], act[63:0], exp[W-1:W-64], exp[63:0]);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_wide();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    // Offer one operation; record its expectation at the moment it is accepted.
    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
        exp_t e;
        logic [W:0] wa;
        logic [W:0] wb;
        bit done;
        done = 0;
        a = av; b = bv; b_in = bi; in_valid = 1'b1;
        for (int t = 0; t < 500 && !done; t++) begin
            @(negedge clk);
            if (in_ready && !rst) begin
                wa = {1'b0, av};
                wb = {1'b0, bv} + {{W{1'b0}}, bi};
                e.d = av - bv - {{(W-1){1'b0}}, bi};
                e.bo = (wa < wb);
                e.acc = cyc + 1;
                q.push_back(e);
                n_acc++;
                done = 1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) chk_int("send_timeout", 0, 1);
    endtask

    task automatic wait_empty();
        bit done;
        done = 0;
        for (int t = 0; t < 1000 && !done; t++) begin
            @(posedge clk); #1;
            if (q.size() == 0) done = 1;
        end
        if (!done) chk_int("drain_timeout", q.size(), 0);
    endtask

    // Monitor: compare every presented result against the queue head.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 0;
            end else begin
                chk_int("busy_state", int'(busy), int'(!out_valid && !in_ready));
                if (out_valid) begin
                    if (q.size() == 0) begin
                        chk_int("spurious_out_valid", 1, 0);
                    end else begin
                        if (!seen) begin
                            chk_int("latency", cyc - q[0].acc, N);
                            seen = 1;
                        end
                        chk_wide("diff", diff, q[0].d);
                        chk_int("b_out", int'(b_out), int'(q[0].bo));
                        chk_int("in_ready_done", int'(in_ready), int'(out_ready));
                        if (out_ready) begin
                            void'(q.pop_front());
                            seen = 0;
                            n_res++;
                        end
                    end
                end
            end
        end
    end

    // Random downstream backpressure during the regression phase.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_or) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1);
    end

    initial begin
        logic [W-1:0] t;
        logic [W-1:0] ones;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int mode;
        ones = '1;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; b_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_int("rst_in_ready", int'(in_ready), 1);
        chk_int("rst_out_valid", int'(out_valid), 0);
        chk_int("rst_busy", int'(busy), 0);
        chk_wide("rst_diff", diff, '0);
        chk_int("rst_b_out", int'(b_out), 0);
        @(posedge clk); #1;

        // Small values, full borrow ripple, chunk boundary, all-ones with borrow-in.
        send(W'(5), W'(3), 1'b0);
        wait_empty();
        send('0, W'(1), 1'b0);
        t = '0; t[64] = 1'b1;
        send(t, W'(1), 1'b0);
        send(ones, ones, 1'b1);
        wait_empty();

        // Backpressure in DONE, then same-edge consume + accept.
        out_ready = 1'b0;
        send(W'(123), W'(45), 1'b0);
        for (int k = 0; k < 100 && !out_valid; k++) @(negedge clk);
        chk_int("bp_out_valid", int'(out_valid), 1);
        @(posedge clk); #1;
        repeat (10) begin @(posedge clk); #1; end
        chk_int("bp_in_ready", int'(in_ready), 0);
        chk_int("bp_hold_valid", int'(out_valid), 1);
        out_ready = 1'b1;
        send(W'(9), W'(4), 1'b0);
        wait_empty();

        // Reset in the middle of RUN discards the operation.
        send(W'(100), W'(1), 1'b0);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        n_acc = n_acc - q.size();
        q.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk_int("abort_out_valid", int'(out_valid), 0);
        chk_int("abort_in_ready", int'(in_ready), 1);
        chk_int("abort_busy", int'(busy), 0);
        chk_wide("abort_diff", diff, '0);
        @(posedge clk); #1;
        send(W'(7), W'(7), 1'b0);
        wait_empty();

        // Random regression with operand patterns that stress borrows.
        rand_or = 1;
        for (int i = 0; i < 1000; i++) begin
            mode = $urandom_range(0, 5);
            ra = rand_wide();
            rb = rand_wide();
            case (mode)
                1: ra = '0;
                2: rb = ones;
                3: rb = ra;
                4: rb = ra + W'($urandom_range(0, 3));
                5: ra = W'($urandom());
                default: ;
            endcase
            send(ra, rb, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        rand_or = 0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_empty();
        @(negedge clk);
        chk_int("result_count", n_res, n_acc);
        chk_int("final_out_valid", int'(out_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
